regfile_wb_queue: RTL and testbench
===================================

Name: regfile_wb_queue

Overview:
Writeback-side driver for the 32x32 CPU register file. It owns the Write_register / Write_data / RegWrite interface. It collects results from the ALU path and the load (memory) path, and buffers them in a small in-order queue. It then drains at most one register-file write per cycle. It also provides combinational forwarding of pending (not yet written) results to the decode-stage read ports.

Parameters:
DEPTH, 4, queue entries; power of 2, minimum 2
DW, 32, data width
AW, 5, register index width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
mem_valid  in  1  load result valid
mem_rd  in  AW  load destination register
mem_data  in  DW  load result
mem_ready  out  1  load result accepted when mem_valid & mem_ready
alu_valid  in  1  ALU result valid
alu_rd  in  AW  ALU destination register
alu_data  in  DW  ALU result
alu_ready  out  1  ALU result accepted when alu_valid & alu_ready
Write_register  out  AW  register-file write index
Write_data  out  DW  register-file write data
RegWrite  out  1  register-file write enable
fwd_addr1  in  AW  decode read address 1
fwd_addr2  in  AW  decode read address 2
fwd_hit1  out  1  pending write to fwd_addr1 exists
fwd_hit2  out  1  pending write to fwd_addr2 exists
fwd_data1  out  DW  youngest pending data for fwd_addr1
fwd_data2  out  DW  youngest pending data for fwd_addr2
count  out  clog2(DEPTH)+1  occupied queue entries
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (rst low, asynchronous): rd/wr pointers and count go to 0. RegWrite, Write_register and Write_data go to 0. Queued entries are discarded, including when reset arrives mid-drain. After release: empty=1, full=0, mem_ready=1, alu_ready=1.
- Ready logic is combinational from the current count, with no credit for a same-cycle dequeue:
  - mem_ready = (count < DEPTH).
  - alu_ready = (count + m < DEPTH), where m = 1 if a load with mem_rd != 0 is accepted this cycle, else 0.
- Writes to x0: an accepted beat with rd == 0 is consumed but not stored. It never raises RegWrite and never forwards.
- Enqueue order: when both paths are accepted in the same cycle, the load entry is written first (older instruction), then the ALU entry. Up to 2 enqueues per cycle.
- Drain: on each rising edge with count != 0 (count sampled before that edge's enqueues), the head is popped into the output registers and RegWrite=1 for the following cycle. Otherwise RegWrite=0, and Write_register/Write_data hold their last values.
- Latency: a beat accepted at edge E is at the head after E. If the queue was otherwise empty, it appears on Write_* with RegWrite=1 after edge E+1. Throughput is 1 write/cycle.
- count next = count + enqueues - dequeue. Pointers wrap modulo DEPTH. Simultaneous enqueue and dequeue while full is impossible, because ready was already low.
- Forwarding (combinational):
  - Candidates are all valid queue entries plus the output stage while RegWrite=1.
  - The youngest matching entry wins. The output stage is the oldest candidate.
  - fwd_hitN=0 when fwd_addrN == 0 or there is no match; fwd_dataN=0 when fwd_hitN=0.
  - Beats being enqueued in the current cycle are not visible to forwarding until after the edge.
- full and empty are derived directly from count.

Test Plan:
- Reset then a single ALU beat (rd=5, data=0x1234) -> alu_ready=1. One cycle later: count=1, fwd_addr1=5 gives hit1=1, data1=0x1234. Next cycle: RegWrite=1, Write_register=5, Write_data=0x1234, count=0.
- Same-cycle load (rd=3, 0xAAAA) and ALU (rd=3, 0xBBBB) -> drains in order 0xAAAA then 0xBBBB. While both are pending, fwd on rd=3 returns 0xBBBB.
- Hold the queue stalled until full is reached: DEPTH=4, then assert both valids -> mem_ready=0 and alu_ready=0 until the first dequeue. count never exceeds 4, and full=1 for exactly the full cycles.
- Beat with rd=0 (data=0xFFFF) -> accepted, count unchanged, RegWrite stays 0, fwd on addr 0 gives hit=0.
- Assert rst low asynchronously with 3 entries pending and RegWrite=1 -> RegWrite=0, Write_*=0, count=0, empty=1 immediately without a clock edge. No stale write after release.
- Continuous back-to-back ALU beats with rd=1..8 -> 8 consecutive RegWrite cycles with matching rd/data, count steady at ≤1, pointers wrap correctly past DEPTH.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
//   Writeback-side driver for the 32x32 register file. Results from the load
//   path and the ALU path are merged into a small in-order queue. The queue
//   drains at most one register-file write per cycle through registered
//   Write_register / Write_data / RegWrite outputs. Pending results are
//   forwarded combinationally to the two decode read ports.
//
//   Ports
//     clk, rst              clock (rising edge), async active-low reset
//     mem_valid/rd/data     load result beat; mem_ready handshake
//     alu_valid/rd/data     ALU result beat;  alu_ready handshake
//     Write_register/_data  register-file write index / data
//     RegWrite              register-file write enable
//     fwd_addr1/2           decode read addresses
//     fwd_hit1/2, data1/2   youngest pending write to that address
//     count, full, empty    queue occupancy
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_rd,
    input  logic [DW-1:0]            mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [DW-1:0]            alu_data,
    output logic                     alu_ready,
    output logic [AW-1:0]            Write_register,
    output logic [DW-1:0]            Write_data,
    output logic                     RegWrite,
    input  logic [AW-1:0]            fwd_addr1,
    input  logic [AW-1:0]            fwd_addr2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DW-1:0]            fwd_data1,
    output logic [DW-1:0]            fwd_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] rd_q   [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          regwrite_q;
    logic [AW-1:0] wreg_q;
    logic [DW-1:0] wdata_q;

    logic          mem_st, alu_st, deq;
    logic [CW-1:0] n_enq;
    logic [PW-1:0] alu_slot;

    // Readiness looks only at the current occupancy; a same-cycle pop gives
    // no credit. The ALU must leave room for a load stored this cycle.
    assign mem_ready = (count_q < DEPTH_C);
    assign mem_st    = mem_valid & mem_ready & (mem_rd != '0);
    assign alu_ready = ((count_q + CW'(mem_st)) < DEPTH_C);
    // Beats to x0 handshake normally but are dropped here.
    assign alu_st    = alu_valid & alu_ready & (alu_rd != '0);
    assign deq       = (count_q != '0);

    assign n_enq    = CW'(mem_st) + CW'(alu_st);
    assign count_d  = count_q + n_enq - CW'(deq);
    assign wr_ptr_d = wr_ptr_q + PW'(n_enq);
    // Load is the older instruction, so it takes the first free slot.
    assign alu_slot = mem_st ? wr_ptr_q + PW'(1) : wr_ptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (mem_st) begin
                rd_q[wr_ptr_q]   <= mem_rd;
                data_q[wr_ptr_q] <= mem_data;
            end
            if (alu_st) begin
                rd_q[alu_slot]   <= alu_rd;
                data_q[alu_slot] <= alu_data;
            end
            // Write_* hold their last values when nothing drains.
            if (deq) begin
                regwrite_q <= 1'b1;
                wreg_q     <= rd_q[rd_ptr_q];
                wdata_q    <= data_q[rd_ptr_q];
                rd_ptr_q   <= rd_ptr_q + PW'(1);
            end else begin
                regwrite_q <= 1'b0;
            end
        end
    end

    // Forwarding: walk candidates oldest to youngest (output stage first,
    // then queue from head) so the last match is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        if (regwrite_q && wreg_q == fwd_addr1) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = wdata_q;
        end
        if (regwrite_q && wreg_q == fwd_addr2) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (rd_q[idx] == fwd_addr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_q[idx];
                end
                if (rd_q[idx] == fwd_addr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_q[idx];
                end
            end
        end
        if (fwd_addr1 == '0) begin
            fwd_hit1  = 1'b0;
            fwd_data1 = '0;
        end
        if (fwd_addr2 == '0) begin
            fwd_hit2  = 1'b0;
            fwd_data2 = '0;
        end
    end

    assign RegWrite       = regwrite_q;
    assign Write_register = wreg_q;
    assign Write_data     = wdata_q;
    assign count          = count_q;
    assign full           = (count_q == DEPTH_C);
    assign empty          = (count_q == '0);

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_valid, alu_valid;
    logic [AW-1:0] mem_rd, alu_rd;
    logic [DW-1:0] mem_data, alu_data;
    logic          mem_ready, alu_ready;
    logic [AW-1:0] Write_register;
    logic [DW-1:0] Write_data;
    logic          RegWrite;
    logic [AW-1:0] fwd_addr1, fwd_addr2;
    logic          fwd_hit1, fwd_hit2;
    logic [DW-1:0] fwd_data1, fwd_data2;
    logic [CW-1:0] count;
    logic          full, empty;

    always #5 clk = ~clk;

    regfile_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .Write_register(Write_register), .Write_data(Write_data), .RegWrite(RegWrite),
        .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count), .full(full), .empty(empty)
    );

    // Reference model: list of pending writes (oldest first) plus the
    // register-file write presented this cycle.
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;
    ent_t          mq[$];
    logic          e_rw;
    logic [AW-1:0] e_wr;
    logic [DW-1:0] e_wd;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic drive(input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                         input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad);
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    function automatic bit m_mem_rdy();
        return mq.size() < DEPTH;
    endfunction

    function automatic bit m_alu_rdy();
        int extra;
        extra = (mem_valid && mq.size() < DEPTH && mem_rd != 0) ? 1 : 0;
        return (mq.size() + extra) < DEPTH;
    endfunction

    task automatic fwd_model(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
        h = 1'b0; d = '0;
        if (a != 0) begin
            if (e_rw && e_wr == a) begin h = 1'b1; d = e_wd; end
            foreach (mq[i]) if (mq[i].rd == a) begin h = 1'b1; d = mq[i].data; end
        end
    endtask

    // Advance one clock edge and update the model with the same inputs.
    task automatic tick();
        bit   ms, as;
        ent_t me, ae;
        ms = mem_valid && m_mem_rdy() && mem_rd != 0;
        as = alu_valid && m_alu_rdy() && alu_rd != 0;
        me.rd = mem_rd; me.data = mem_data;
        ae.rd = alu_rd; ae.data = alu_data;
        @(posedge clk);
        if (mq.size() > 0) begin
            e_rw = 1'b1; e_wr = mq[0].rd; e_wd = mq[0].data;
            void'(mq.pop_front());
        end else begin
            e_rw = 1'b0;
        end
        if (ms) mq.push_back(me);
        if (as) mq.push_back(ae);
        #1;
    endtask

    task automatic do_reset();
        idle();
        fwd_addr1 = '0; fwd_addr2 = '0;
        rst = 1'b0;
        mq.delete(); e_rw = 1'b0; e_wr = '0; e_wd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (count !== 0)        begin n_errs++; $display("FAIL rst_count: got %0d exp 0", count); end
        n_checks++; if (empty !== 1'b1)     begin n_errs++; $display("FAIL rst_empty: got %0b exp 1", empty); end
        n_checks++; if (full !== 1'b0)      begin n_errs++; $display("FAIL rst_full: got %0b exp 0", full); end
        n_checks++; if (mem_ready !== 1'b1) begin n_errs++; $display("FAIL rst_mem_ready: got %0b exp 1", mem_ready); end
        n_checks++; if (alu_ready !== 1'b1) begin n_errs++; $display("FAIL rst_alu_ready: got %0b exp 1", alu_ready); end
        n_checks++; if (RegWrite !== 1'b0)  begin n_errs++; $display("FAIL rst_regwrite: got %0b exp 0", RegWrite); end
        n_checks++; if (Write_register !== 0 || Write_data !== 0)
            begin n_errs++; $display("FAIL rst_write: got %0h/%0h exp 0/0", Write_register, Write_data); end
    endtask

    task automatic test_single_alu();
        do_reset();
        drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h1234);
        #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_errs++; $display("FAIL sa_ready: got %0b exp 1", alu_ready); end
        tick();
        idle(); fwd_addr1 = 5'd5; #1;
        n_checks++; if (count !== 1) begin n_errs++; $display("FAIL sa_count1: got %0d exp 1", count); end
        n_checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h1234)
            begin n_errs++; $display("FAIL sa_fwd: got %0b/%0h exp 1/1234", fwd_hit1, fwd_data1); end
        n_checks++; if (RegWrite !== 1'b0) begin n_errs++; $display("FAIL sa_early_rw: got %0b exp 0", RegWrite); end
        tick();
        n_checks++; if (RegWrite !== 1'b1 || Write_register !== 5'd5 || Write_data !== 32'h1234)
            begin n_errs++; $display("FAIL sa_write: got %0b/%0d/%0h exp 1/5/1234", RegWrite, Write_register, Write_data); end
        n_checks++; if (count !== 0) begin n_errs++; $display("FAIL sa_count0: got %0d exp 0", count); end
        n_checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h1234)
            begin n_errs++; $display("FAIL sa_fwd_out: got %0b/%0h exp 1/1234", fwd_hit1, fwd_data1); end
        tick();
        n_checks++; if (RegWrite !== 1'b0 || Write_data !== 32'h1234)
            begin n_errs++; $display("FAIL sa_hold: got %0b/%0h exp 0/1234", RegWrite, Write_data); end
        n_checks++; if (fwd_hit1 !== 1'b0) begin n_errs++; $display("FAIL sa_fwd_gone: got %0b exp 0", fwd_hit1); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB);
        fwd_addr1 = 5'd3; #1;
        n_checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1)
            begin n_errs++; $display("FAIL sc_ready: got %0b%0b exp 11", mem_ready, alu_ready); end
        n_checks++; if (fwd_hit1 !== 1'b0) begin n_errs++; $display("FAIL sc_fwd_early: got %0b exp 0", fwd_hit1); end
        tick();
        idle(); #1;
        n_checks++; if (count !== 2) begin n_errs++; $display("FAIL sc_count: got %0d exp 2", count); end
        n_checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hBBBB)
            begin n_errs++; $display("FAIL sc_fwd_young: got %0b/%0h exp 1/bbbb", fwd_hit1, fwd_data1); end
        tick();
        n_checks++; if (RegWrite !== 1'b1 || Write_register !== 5'd3 || Write_data !== 32'hAAAA)
            begin n_errs++; $display("FAIL sc_first: got %0b/%0d/%0h exp 1/3/aaaa", RegWrite, Write_register, Write_data); end
        n_checks++; if (fwd_data1 !== 32'hBBBB) begin n_errs++; $display("FAIL sc_fwd_mid: got %0h exp bbbb", fwd_data1); end
        tick();
        n_checks++; if (RegWrite !== 1'b1 || Write_data !== 32'hBBBB)
            begin n_errs++; $display("FAIL sc_second: got %0b/%0h exp 1/bbbb", RegWrite, Write_data); end
        tick();
        n_checks++; if (RegWrite !== 1'b0) begin n_errs++; $display("FAIL sc_done: got %0b exp 0", RegWrite); end
    endtask

    task automatic test_x0();
        do_reset();
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF);
        fwd_addr1 = 5'd0; #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_errs++; $display("FAIL x0_ready: got %0b exp 1", alu_ready); end
        tick();
        idle(); #1;
        n_checks++; if (count !== 0) begin n_errs++; $display("FAIL x0_count: got %0d exp 0", count); end
        n_checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 0)
            begin n_errs++; $display("FAIL x0_fwd: got %0b/%0h exp 0/0", fwd_hit1, fwd_data1); end
        tick();
        n_checks++; if (RegWrite !== 1'b0) begin n_errs++; $display("FAIL x0_rw: got %0b exp 0", RegWrite); end
        // A dropped x0 load must not steal room from the ALU beat.
        drive(1'b1, 5'd0, 32'h1, 1'b1, 5'd7, 32'h77); #1;
        tick(); tick();
        n_checks++; if (RegWrite !== 1'b1 || Write_register !== 5'd7 || Write_data !== 32'h77)
            begin n_errs++; $display("FAIL x0_mixed: got %0b/%0d/%0h exp 1/7/77", RegWrite, Write_register, Write_data); end
    endtask

    task automatic test_pressure(input int cycles);
        logic          h;
        logic [DW-1:0] d;
        int            full_cycles, exp_full_cycles;
        full_cycles = 0; exp_full_cycles = 0;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            drive($urandom_range(0, 7) != 0, AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 7) != 0, AW'($urandom_range(0, 7)), $urandom);
            fwd_addr1 = AW'($urandom_range(0, 7));
            fwd_addr2 = AW'($urandom_range(0, 7));
            #1;
            n_checks++; if (mem_ready !== m_mem_rdy())
                begin n_errs++; $display("FAIL pr_mem_ready: got %0b exp %0b", mem_ready, m_mem_rdy()); end
            n_checks++; if (alu_ready !== m_alu_rdy())
                begin n_errs++; $display("FAIL pr_alu_ready: got %0b exp %0b", alu_ready, m_alu_rdy()); end
            fwd_model(fwd_addr1, h, d);
            n_checks++; if (fwd_hit1 !== h || fwd_data1 !== d)
                begin n_errs++; $display("FAIL pr_fwd1: got %0b/%0h exp %0b/%0h", fwd_hit1, fwd_data1, h, d); end
            fwd_model(fwd_addr2, h, d);
            n_checks++; if (fwd_hit2 !== h || fwd_data2 !== d)
                begin n_errs++; $display("FAIL pr_fwd2: got %0b/%0h exp %0b/%0h", fwd_hit2, fwd_data2, h, d); end
            tick();
            if (full) full_cycles++;
            if (mq.size() == DEPTH) exp_full_cycles++;
            n_checks++; if (count !== CW'(mq.size()) || count > DEPTH)
                begin n_errs++; $display("FAIL pr_count: got %0d exp %0d", count, mq.size()); end
            n_checks++; if (empty !== (mq.size() == 0))
                begin n_errs++; $display("FAIL pr_empty: got %0b exp %0b", empty, mq.size() == 0); end
            n_checks++; if (RegWrite !== e_rw || Write_register !== e_wr || Write_data !== e_wd)
                begin n_errs++; $display("FAIL pr_write: got %0b/%0d/%0h exp %0b/%0d/%0h",
                                         RegWrite, Write_register, Write_data, e_rw, e_wr, e_wd); end
        end
        n_checks++; if (full_cycles !== exp_full_cycles)
            begin n_errs++; $display("FAIL pr_full_cycles: got %0d exp %0d", full_cycles, exp_full_cycles); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22); #1;
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44); #1;
        tick();
        idle();
        n_checks++; if (count !== 3 || RegWrite !== 1'b1)
            begin n_errs++; $display("FAIL ar_pre: got %0d/%0b exp 3/1", count, RegWrite); end
        #1 rst = 1'b0;
        #1;
        n_checks++; if (RegWrite !== 1'b0 || Write_register !== 0 || Write_data !== 0)
            begin n_errs++; $display("FAIL ar_write: got %0b/%0d/%0h exp 0/0/0", RegWrite, Write_register, Write_data); end
        n_checks++; if (count !== 0 || empty !== 1'b1)
            begin n_errs++; $display("FAIL ar_count: got %0d/%0b exp 0/1", count, empty); end
        mq.delete(); e_rw = 1'b0; e_wr = '0; e_wd = '0;
        #13 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (RegWrite !== 1'b0 || count !== 0)
                begin n_errs++; $display("FAIL ar_stale: got %0b/%0d exp 0/0", RegWrite, count); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) drive(1'b0, '0, '0, 1'b1, AW'(k), 32'hC000 + k);
            else        idle();
            #1;
            n_checks++; if (alu_ready !== 1'b1) begin n_errs++; $display("FAIL bb_ready%0d: got %0b exp 1", k, alu_ready); end
            tick();
            if (k >= 2) begin
                n_checks++; if (RegWrite !== 1'b1 || Write_register !== AW'(k - 1) || Write_data !== 32'hC000 + k - 1)
                    begin n_errs++; $display("FAIL bb_write%0d: got %0b/%0d/%0h exp 1/%0d/%0h",
                                             k, RegWrite, Write_register, Write_data, k - 1, 32'hC000 + k - 1); end
            end
            n_checks++; if (count !== ((k <= 8) ? 1 : 0))
                begin n_errs++; $display("FAIL bb_count%0d: got %0d", k, count); end
        end
        tick();
        n_checks++; if (RegWrite !== 1'b0) begin n_errs++; $display("FAIL bb_end: got %0b exp 0", RegWrite); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        fwd_addr1 = '0; fwd_addr2 = '0;
        e_rw = 1'b0; e_wr = '0; e_wd = '0;
        test_reset();
        test_single_alu();
        test_same_cycle();
        test_x0();
        test_pressure(400);
        test_async_reset();
        test_back_to_back();
        test_pressure(300);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
